// File: rtl/cdr_ctrl_pkg.sv
// Shared types for the CDR acquisition controller: sequencer state encoding and helpers.
package cdr_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StAcq    = 2'd2,
    StTrack  = 2'd3
  } cdr_state_t;

  // States in which the loop integrates and the error window runs.
  function automatic logic in_loop(cdr_state_t s);
    return (s == StAcq) || (s == StTrack);
  endfunction

endpackage

// File: rtl/cdr_win_acc.sv
// PD error window accumulator: sums pd_i over 2**WIN_LOG2 cycles and registers a
// good/bad verdict against the lock and unlock thresholds on the cycle after the window.
module cdr_win_acc #(
  parameter int unsigned PD_W     = 10,
  parameter int unsigned WIN_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      active,
  input  logic                      clear,
  input  logic signed [PD_W-1:0]    pd_i,
  input  logic [PD_W+WIN_LOG2-1:0]  lock_thr,
  input  logic [PD_W+WIN_LOG2-1:0]  unlock_thr,
  output logic                      win_done,
  output logic                      win_good,
  output logic                      win_bad
);

  localparam int unsigned AccW = PD_W + WIN_LOG2 + 1;

  logic signed [AccW-1:0] acc_q, acc_d;
  logic signed [AccW-1:0] pd_ext, sum;
  logic [AccW-1:0]        sum_abs;
  logic [WIN_LOG2-1:0]    cnt_q, cnt_d;
  logic                   last;
  logic                   done_q, done_d;
  logic                   good_q, good_d;
  logic                   bad_q, bad_d;

  assign pd_ext = {{(AccW - PD_W){pd_i[PD_W-1]}}, pd_i};
  assign sum    = acc_q + pd_ext;
  // One spare bit over the worst-case sum keeps the most-negative magnitude exact.
  assign sum_abs = sum[AccW-1] ? $unsigned(-sum) : $unsigned(sum);
  assign last    = (cnt_q == {WIN_LOG2{1'b1}});

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    good_d = good_q;
    bad_d  = bad_q;
    if (clear) begin
      acc_d  = '0;
      cnt_d  = '0;
      good_d = 1'b0;
      bad_d  = 1'b0;
    end else if (active) begin
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        acc_d  = '0;
        done_d = 1'b1;
        good_d = (sum_abs <= {1'b0, lock_thr});
        bad_d  = (sum_abs >  {1'b0, unlock_thr});
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      good_q <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign win_done = done_q;
  assign win_good = good_q;
  assign win_bad  = bad_q;

endmodule

// File: rtl/cdr_acq_ctrl.sv
// CDR loop acquisition sequencer: IDLE -> SETTLE -> ACQ <-> TRACK with windowed lock detect.
// Define CDR_ACQ_CTRL_DBG_EN to build the saturating TRACK->ACQ relock counter.
module cdr_acq_ctrl
  import cdr_ctrl_pkg::*;
#(
  parameter int unsigned PD_W       = 10,
  parameter int unsigned WIN_LOG2   = 4,
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 2,
  parameter int unsigned SHIFT_W    = 4,
  parameter int unsigned ACQ_SHIFT  = 4,
  parameter int unsigned TRK_SHIFT  = 8
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      en,
  input  logic signed [PD_W-1:0]    pd_i,
  input  logic [PD_W+WIN_LOG2-1:0]  lock_thr,
  input  logic [PD_W+WIN_LOG2-1:0]  unlock_thr,
  output logic                      loop_en,
  output logic [SHIFT_W-1:0]        filt_shift,
  output logic                      lock,
  output logic [1:0]                state_o,
  output logic [7:0]                relock_cnt
);

  localparam int unsigned SetW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BadW  = $clog2(UNLOCK_CNT + 1);

  cdr_state_t         state_q, state_d;
  logic [SetW-1:0]    settle_q, settle_d;
  logic [GoodW-1:0]   good_q, good_d;
  logic [BadW-1:0]    bad_q, bad_d;
  logic               win_done, win_good, win_bad;
  logic               win_active, win_clear;
  logic               acq_lock, trk_drop;
  logic               loop_en_q, loop_en_d;
  logic               lock_q, lock_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;

  assign win_active = in_loop(state_q);
  // Any state change or leaving the loop states restarts the window from an empty sum.
  assign win_clear  = !in_loop(state_d) || (state_d != state_q);

  cdr_win_acc #(
    .PD_W     (PD_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_win_acc (
    .clk        (clk),
    .rstb       (rstb),
    .active     (win_active),
    .clear      (win_clear),
    .pd_i       (pd_i),
    .lock_thr   (lock_thr),
    .unlock_thr (unlock_thr),
    .win_done   (win_done),
    .win_good   (win_good),
    .win_bad    (win_bad)
  );

  // Act on the verdict cycle itself so TRACK follows the last good verdict by one cycle.
  assign acq_lock = win_done && win_good && (good_q == GoodW'(LOCK_CNT - 1));
  assign trk_drop = win_done && win_bad  && (bad_q  == BadW'(UNLOCK_CNT - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StSettle;
        StSettle: if (settle_q == SetW'(SETTLE_CYC - 1)) state_d = StAcq;
        StAcq:    if (acq_lock) state_d = StTrack;
        StTrack:  if (trk_drop) state_d = StAcq;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    loop_en_d = in_loop(state_d);
    lock_d    = (state_d == StTrack);
    shift_d   = (state_d == StTrack) ? SHIFT_W'(TRK_SHIFT) : SHIFT_W'(ACQ_SHIFT);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      loop_en_q <= 1'b0;
      lock_q    <= 1'b0;
      shift_q   <= SHIFT_W'(ACQ_SHIFT);
    end else begin
      loop_en_q <= loop_en_d;
      lock_q    <= lock_d;
      shift_q   <= shift_d;
    end
  end

  // Counters only survive while the state is held; every transition restarts them.
  always_comb begin
    settle_d = '0;
    good_d   = '0;
    bad_d    = '0;
    if (state_q == StSettle && state_d == StSettle) begin
      settle_d = settle_q + 1'b1;
    end
    if (state_q == StAcq && state_d == StAcq) begin
      good_d = good_q;
      if (win_done) good_d = win_good ? good_q + 1'b1 : '0;
    end
    if (state_q == StTrack && state_d == StTrack) begin
      bad_d = bad_q;
      if (win_done) bad_d = win_bad ? bad_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      settle_q <= '0;
      good_q   <= '0;
      bad_q    <= '0;
    end else begin
      settle_q <= settle_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
    end
  end

`ifdef CDR_ACQ_CTRL_DBG_EN
  logic [7:0] relock_q;

  // Survives en toggles on purpose; only rstb clears the history.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      relock_q <= '0;
    end else if (state_q == StTrack && state_d == StAcq && relock_q != 8'hff) begin
      relock_q <= relock_q + 8'd1;
    end
  end

  assign relock_cnt = relock_q;
`else
  assign relock_cnt = 8'd0;
`endif

  assign loop_en    = loop_en_q;
  assign filt_shift = shift_q;
  assign lock       = lock_q;
  assign state_o    = state_q;

endmodule
